// File: rtl/async_wr_packer.sv
// async_wr_packer
//
// Write-side packer sitting directly upstream of the two-stage async FIFO in
// the wclk domain. It collects RATIO narrow beats from a valid/ready stream
// into one FIFO word. Lane 0 is the first beat, placed in the LSBs. The word
// is presented on the FIFO write port and held until the FIFO accepts it.
// A partial word is emitted zero-padded when in_last is seen, or when flush
// is requested. word_cnt is a wrapping debug count of words taken by the FIFO.
//
// Parameters:
//   IN_WID   width of one input beat
//   RATIO    beats per FIFO word (minimum 2); word width is IN_WID*RATIO
//
// Ports:
//   wclk      in   write-domain clock, all logic on posedge
//   rst_nw    in   asynchronous active-low reset
//   in_valid  in   input beat valid
//   in_ready  out  packer can take a beat this cycle
//   in_data   in   beat payload
//   in_last   in   beat closes the current word, even if partial
//   flush     in   level request to emit a pending partial word
//   writex    out  FIFO write request
//   wfull     in   FIFO full
//   wdata     out  FIFO write data
//   word_cnt  out  words accepted by the FIFO, wraps modulo 2^16

module async_wr_packer #(
  parameter int IN_WID = 8,
  parameter int RATIO  = 4
) (
  input  logic                      wclk,
  input  logic                      rst_nw,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WID-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      flush,
  output logic                      writex,
  input  logic                      wfull,
  output logic [IN_WID*RATIO-1:0]   wdata,
  output logic [15:0]               word_cnt
);

  localparam int OUT_WID = IN_WID * RATIO;
  localparam int IDX_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [OUT_WID-1:0] acc;
  logic [OUT_WID-1:0] odata;
  logic [OUT_WID-1:0] merged;
  logic [IDX_W-1:0]   idx;
  logic               ovalid;

  logic out_take;
  logic out_free;
  logic accept;
  logic last_lane;
  logic complete;
  logic flush_act;

  assign writex = ovalid;
  assign wdata  = odata;

  // The output register can take a new word whenever it is empty or its
  // current word leaves this cycle, so input readiness only depends on that.
  assign out_take = ovalid && !wfull;
  assign out_free = !ovalid || !wfull;
  assign in_ready = out_free;
  assign accept   = in_valid && out_free;

  // A flush arriving together with an accepted beat behaves like in_last on
  // that beat, so it is folded into the completing condition here.
  assign last_lane = (idx == IDX_W'(RATIO - 1));
  assign complete  = accept && (last_lane || in_last || flush);

  // A standalone flush only matters if something is pending in the
  // accumulator; with idx at 0 it does nothing.
  assign flush_act = flush && out_free && (idx != '0) && !accept;

  // Accumulator with the incoming beat dropped into lane idx. Lanes above idx
  // are forced to zero so a partial word always goes out zero-padded.
  always_comb begin
    merged = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(idx)) begin
        merged[i*IN_WID +: IN_WID] = acc[i*IN_WID +: IN_WID];
      end else if (i == int'(idx)) begin
        merged[i*IN_WID +: IN_WID] = in_data;
      end
    end
  end

  // Packing state and output register. Loading a new word takes priority
  // over clearing ovalid, so a word leaving and a word arriving in the same
  // cycle keeps writex high with the new data.
  always_ff @(posedge wclk or negedge rst_nw) begin
    if (!rst_nw) begin
      acc      <= '0;
      idx      <= '0;
      ovalid   <= 1'b0;
      odata    <= '0;
      word_cnt <= '0;
    end else begin
      if (out_take) begin
        word_cnt <= word_cnt + 16'd1;
      end

      if (complete) begin
        odata  <= merged;
        ovalid <= 1'b1;
        acc    <= '0;
        idx    <= '0;
      end else if (flush_act) begin
        odata  <= acc;
        ovalid <= 1'b1;
        acc    <= '0;
        idx    <= '0;
      end else begin
        if (accept) begin
          acc <= merged;
          idx <= idx + 1'b1;
        end
        if (out_take) begin
          ovalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_async_wr_packer.sv
// tb_async_wr_packer
//
// Self-checking bench for async_wr_packer with IN_WID=8, RATIO=4. Words the
// FIFO should receive are queued when the stimulus is driven. They are popped
// and compared whenever the FIFO write handshake completes. A table of beats
// covers continuous and partial packing; hand sequences cover flush,
// backpressure, reset mid-word and word_cnt wrap.

module tb_async_wr_packer;

  localparam int IN_WID  = 8;
  localparam int RATIO   = 4;
  localparam int OUT_WID = IN_WID * RATIO;

  logic               wclk = 1'b0;
  logic               rst_nw;
  logic               in_valid;
  logic               in_ready;
  logic [IN_WID-1:0]  in_data;
  logic               in_last;
  logic               flush;
  logic               writex;
  logic               wfull;
  logic [OUT_WID-1:0] wdata;
  logic [15:0]        word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [OUT_WID-1:0] exp_q[$];
  logic [15:0]        exp_cnt;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        emit;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  async_wr_packer #(
    .IN_WID (IN_WID),
    .RATIO  (RATIO)
  ) dut (
    .wclk     (wclk),
    .rst_nw   (rst_nw),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .flush    (flush),
    .writex   (writex),
    .wfull    (wfull),
    .wdata    (wdata),
    .word_cnt (word_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // One clock cycle. At the negedge, in_ready is sampled, and any FIFO
  // handshake about to happen at the next posedge is scored against the queue.
  task automatic tick(output logic rdy);
    @(negedge wclk);
    rdy = in_ready;
    if (rst_nw && writex && !wfull) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word: got %h, want none", wdata);
      end else begin
        check_output("fifo_word", wdata, exp_q.pop_front());
      end
      exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    logic r;
    for (int k = 0; k < n; k++) tick(r);
  endtask

  // Drive one beat and hold it until accepted. When emit is set, the word
  // this beat completes is queued as the next expected FIFO word.
  task automatic apply_stimulus(input logic [7:0] data, input logic last, input logic fl,
                                input logic emit, input logic [31:0] exp, output int cycles);
    logic rdy;
    bit   done;
    done     = 1'b0;
    cycles   = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    flush    = fl;
    if (emit) exp_q.push_back(exp);
    while (!done && cycles < 100) begin
      tick(rdy);
      cycles++;
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no in_ready, want acceptance of %h", data);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic rdy;
    logic [15:0] cnt_before;

    vecs[0]  = '{8'h01, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{8'h02, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{8'h03, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{8'h04, 1'b0, 1'b1, 32'h04030201};
    vecs[4]  = '{8'h05, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{8'h06, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{8'h07, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{8'h08, 1'b0, 1'b1, 32'h08070605};
    vecs[8]  = '{8'hAA, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{8'hBB, 1'b1, 1'b1, 32'h0000BBAA};
    vecs[10] = '{8'hCC, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{8'hDD, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{8'hEE, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{8'hFF, 1'b0, 1'b1, 32'hFFEEDDCC};

    rst_nw   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    flush    = 1'b0;
    wfull    = 1'b0;
    exp_cnt  = '0;

    // Reset state
    #2;
    check_output("reset_writex", 32'(writex), 32'd0);
    check_output("reset_wdata", wdata, 32'd0);
    check_output("reset_word_cnt", 32'(word_cnt), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    wait_cycles(2);
    rst_nw = 1'b1;
    wait_cycles(1);

    // Continuous and partial packing from the table
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].last, 1'b0, vecs[i].emit, vecs[i].exp, cyc);
      check_output("beat_accept_cycles", 32'(cyc), 32'd1);
      if (vecs[i].emit) begin
        check_output("latency_writex", 32'(writex), 32'd1);
        check_output("latency_wdata", wdata, vecs[i].exp);
      end
    end
    wait_cycles(2);
    check_output("table_queue_drained", 32'(exp_q.size()), 32'd0);
    check_output("table_word_cnt", 32'(word_cnt), 32'd4);

    // Flush of a 3-beat partial word after idle cycles
    apply_stimulus(8'h11, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'h22, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'h33, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    for (int k = 0; k < 3; k++) begin
      tick(rdy);
      check_output("flush_idle_writex", 32'(writex), 32'd0);
    end
    flush = 1'b1;
    exp_q.push_back(32'h00332211);
    tick(rdy);
    flush = 1'b0;
    check_output("flush_writex", 32'(writex), 32'd1);
    check_output("flush_wdata", wdata, 32'h00332211);
    tick(rdy);
    check_output("flush_taken_writex", 32'(writex), 32'd0);
    flush = 1'b1;
    tick(rdy);
    flush = 1'b0;
    check_output("flush_idx0_writex", 32'(writex), 32'd0);
    tick(rdy);
    check_output("flush_idx0_writex_later", 32'(writex), 32'd0);

    // Backpressure: hold a word with wfull for 5 cycles while a beat waits
    apply_stimulus(8'hA1, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hA2, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hA3, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hA4, 1'b0, 1'b0, 1'b1, 32'hA4A3A2A1, cyc);
    wfull    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hB1;
    for (int k = 0; k < 5; k++) begin
      tick(rdy);
      check_output("stall_in_ready", 32'(rdy), 32'd0);
      check_output("stall_writex", 32'(writex), 32'd1);
      check_output("stall_wdata", wdata, 32'hA4A3A2A1);
    end
    cnt_before = exp_cnt;
    wfull = 1'b0;
    tick(rdy);
    in_valid = 1'b0;
    check_output("release_in_ready", 32'(rdy), 32'd1);
    check_output("release_word_cnt", 32'(word_cnt), 32'(cnt_before + 16'd1));
    check_output("release_writex", 32'(writex), 32'd0);
    apply_stimulus(8'hB2, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hB3, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hB4, 1'b0, 1'b0, 1'b1, 32'hB4B3B2B1, cyc);
    check_output("after_stall_wdata", wdata, 32'hB4B3B2B1);

    // Reset with a partial word pending
    apply_stimulus(8'hC1, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hC2, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    rst_nw = 1'b0;
    #1;
    check_output("midreset_writex", 32'(writex), 32'd0);
    check_output("midreset_wdata", wdata, 32'd0);
    check_output("midreset_word_cnt", 32'(word_cnt), 32'd0);
    check_output("midreset_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_cnt = '0;
    tick(rdy);
    rst_nw = 1'b1;
    apply_stimulus(8'hD1, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hD2, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hD3, 1'b0, 1'b0, 1'b0, 32'h0, cyc);
    apply_stimulus(8'hD4, 1'b0, 1'b0, 1'b1, 32'hD4D3D2D1, cyc);
    check_output("postreset_wdata", wdata, 32'hD4D3D2D1);
    tick(rdy);
    check_output("postreset_word_cnt", 32'(word_cnt), 32'd1);

    // word_cnt wrap: 65535 more single-beat words makes 65536 since reset
    for (int i = 0; i < 65535; i++) begin
      apply_stimulus(8'(i), 1'b1, 1'b0, 1'b1, {24'h0, 8'(i)}, cyc);
    end
    tick(rdy);
    check_output("wrap_zero", 32'(word_cnt), 32'd0);
    apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b1, 32'h0000005A, cyc);
    tick(rdy);
    check_output("wrap_one", 32'(word_cnt), 32'd1);
    check_output("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_wr_packer.md
# async_wr_packer

Write-side packer that sits directly upstream of the two-stage async FIFO in the wclk domain. It accepts a narrow valid/ready byte-lane stream, packs RATIO beats into one FIFO word, and drives the FIFO write port (writex/wdata), holding each word until the FIFO accepts it. Partial words are emitted zero-padded on in_last or on flush. A wrapping count of accepted words is reported for debug.

## Interface
- IN_WID, default 8: width of one input beat.
- RATIO, default 4: beats per FIFO word. Minimum 2. OUT_WID = IN_WID*RATIO is derived, not a parameter.
- wclk  input  1  write-domain clock; all logic is posedge wclk.
- rst_nw  input  1  reset, asynchronous, active-low; clock wclk.
- in_valid  input  1  input beat valid.
- in_ready  output  1  packer can take a beat this cycle.
- in_data  input  IN_WID  beat payload.
- in_last  input  1  beat closes the current word; it is emitted even if partial.
- flush  input  1  level request to emit a pending partial word.
- writex  output  1  FIFO write request; connects to the FIFO write input.
- wfull  input  1  FIFO full; connects to the FIFO full output.
- wdata  output  OUT_WID  FIFO write data.
- word_cnt  output  16  count of words accepted by the FIFO; wraps at 16'hFFFF to 0.

## Operation
- State: accumulator acc[OUT_WID-1:0], lane index idx (0..RATIO-1), output register {ovalid, odata}, and word_cnt.
- writex = ovalid and wdata = odata, both directly from registers. The FIFO takes a word when writex && !wfull. That term is out_take.
- out_free = !ovalid || !wfull. in_ready = out_free, purely combinational; it does not depend on in_valid or in_last.
- Accept: in_valid && in_ready. The beat is written into lane idx, bits [idx*IN_WID +: IN_WID]. Lane 0 is the first beat in the LSBs.
- Completing beat: an accepted beat with idx==RATIO-1 or in_last=1.
  - odata <= acc with the new lane merged in; lanes above idx are forced to 0.
  - ovalid <= 1, acc <= 0, idx <= 0.
- Non-completing accepted beat: acc lane updated, idx <= idx+1, output register untouched unless out_take.
- Flush: acts when flush=1 && out_free && idx>0 && no beat accepted that cycle. odata <= acc (upper lanes are already 0), ovalid <= 1, acc <= 0, idx <= 0.
- Flush with idx==0 is a no-op. Flush with a beat accepted in the same cycle treats that beat as in_last=1.
- If out_take and a new word is loaded in the same cycle, ovalid stays 1 and odata takes the new word. If out_take with no load, ovalid <= 0.
- On every out_take, word_cnt <= word_cnt + 1 (16-bit modulo).
- Reset, asynchronous: acc=0, idx=0, ovalid=0, odata=0, word_cnt=0.
  - Resulting outputs: writex=0, wdata=0, word_cnt=0, in_ready=1.
  - A partial word or held word present at reset is discarded.

## Timing
- Latency: completing beat accepted at edge N gives writex=1 with that word from N+1. The FIFO captures it at the first later edge where wfull=0.
- Throughput: 1 beat per cycle while wfull stays 0. A RATIO-beat word is presented every RATIO cycles.
- Backpressure: while ovalid && wfull, in_ready=0 and no beat is accepted, including non-completing ones. writex and wdata hold stable until acceptance.
- wfull high for K cycles with a word held stalls input for exactly K cycles. Nothing is lost or duplicated.
- in_ready may fall while in_valid is high; the upstream must hold its beat.
- The upstream must not change in_data or in_last while in_valid && !in_ready.

## Test plan
- Continuous writes, IN_WID=8, RATIO=4, bytes 01,02,03,04,05..08, wfull=0:
  - writex pulses carry wdata 32'h04030201, then 32'h08070605.
  - The first pulse appears 1 cycle after the 4th beat. word_cnt=2.
- Partial word: bytes AA,BB with in_last on BB:
  - Next cycle wdata=32'h0000BBAA, writex=1. The next word restarts at lane 0.
- Flush: beats 11,22,33 without last, idle 3 cycles, then flush=1 for 1 cycle:
  - wdata=32'h00332211 one cycle later. flush with idx=0 produces no writex.
- Backpressure: force wfull=1 while a word is held, for 5 cycles:
  - in_ready=0 and writex/wdata stay stable for those 5 cycles.
  - Release gives exactly one acceptance; word_cnt increments by 1; no data is lost across the stream.
- Reset mid-word: 2 beats accepted, then rst_nw pulsed low:
  - Immediately writex=0, wdata=0, word_cnt=0, in_ready=1.
  - The next 4 beats form a clean word starting at lane 0.
- word_cnt wrap: preload via 65536 accepted words, then one more:
  - word_cnt reads 0 after the 65536th word and 1 after the next.
